doodle_sprite_renderer: RTL

// Display-side counterpart of the doodle motion block: derives its frame_clk_edge strobe from VGA vsync
// and consumes its Doodle_X/Y position. It latches position and facing once per frame during vblank, then

---
 rtl/doodle_pkg.sv | 42 ++++
 rtl/doodle_sprite_renderer_if.sv | 27 ++
 rtl/doodle_sprite_rom.sv | 19 +
 rtl/doodle_sprite_renderer.sv | 116 +++++++++++
 4 files changed

// File: rtl/doodle_pkg.sv
// Shared constants, types and sprite image for the doodle sprite renderer.
// The sprite image is held here as a 100-entry table of 4-bit palette indices.
package doodle_pkg;

  localparam int SPRITE_W = 10;
  localparam int SPRITE_H = 10;
  localparam int SPRITE_N = SPRITE_W * SPRITE_H;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;

  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;

  typedef logic [3:0] pal_idx_t;
  typedef logic [6:0] rom_addr_t;

  // One hex digit per pixel, one 10-digit group per sprite row, row 0 first; index 0 is transparent.
  localparam logic [SPRITE_N*4-1:0] SPRITE_BITS = {
    40'h0A55555501,
    40'h0555555550,
    40'h5577557755,
    40'h55772C7755,
    40'h5555955555,
    40'h5588888855,
    40'h0555555550,
    40'h0055555500,
    40'h0050050050,
    40'h0B000000B0
  };

  function automatic pal_idx_t sprite_entry(input rom_addr_t a);
    pal_idx_t p;
    if (int'(a) < SPRITE_N) begin
      p = SPRITE_BITS[(SPRITE_N - 1 - int'(a)) * 4 +: 4];
    end else begin
      p = 4'd0;
    end
    return p;
  endfunction

endpackage

// File: rtl/doodle_sprite_renderer_if.sv
// Pixel-stream bundle between the VGA timing side and the sprite renderer.
interface doodle_sprite_renderer_if;
  import doodle_pkg::*;

  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [1:0] frame_clk_edge;
  logic       doodle_on;
  pal_idx_t   doodle_idx;

  modport master (
    output DrawX,
    output DrawY,
    input  frame_clk_edge,
    input  doodle_on,
    input  doodle_idx
  );

  modport slave (
    input  DrawX,
    input  DrawY,
    output frame_clk_edge,
    output doodle_on,
    output doodle_idx
  );

endinterface

// File: rtl/doodle_sprite_rom.sv
// 100 x 4-bit sprite ROM with a registered read port.
module doodle_sprite_rom
  import doodle_pkg::*;
(
  input  logic      Clk,
  input  rom_addr_t addr,
  output pal_idx_t  pix
);

  pal_idx_t pix_r;

  // Registered ROM read; consumers gate the result with their own valid bit.
  always_ff @(posedge Clk) begin
    pix_r <= sprite_entry(addr);
  end

  assign pix = pix_r;

endmodule

// File: rtl/doodle_sprite_renderer.sv
// Latches doodle position/facing once per frame at the vsync falling edge and renders
// the 10x10 sprite as a palette index plus opaque flag, two cycles after DrawX/DrawY.
module doodle_sprite_renderer
  import doodle_pkg::*;
#(
  parameter logic [9:0] SIZE_X      = 10'd10,
  parameter logic [9:0] SIZE_Y      = 10'd10,
  parameter int         SCALE_SHIFT = 1,
  parameter logic [9:0] RST_X       = 10'd155,
  parameter logic [9:0] RST_Y       = 10'd160
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     vga_vs,
  input  logic [7:0]               keycode,
  input  logic [9:0]               Doodle_X_in,
  input  logic [9:0]               Doodle_Y_in,
  doodle_sprite_renderer_if.slave  pix
);

  logic       vs_q0_r;
  logic       vs_q1_r;
  logic [1:0] edge_s;
  logic [9:0] shadow_x_r;
  logic [9:0] shadow_y_r;
  logic       facing_left_r;

  logic [10:0] gx_s;
  logic [10:0] gy_s;
  logic [10:0] sx_s;
  logic [10:0] sy_s;
  logic        in_box_s;
  logic [3:0]  rel_x_s;
  logic [3:0]  rel_y_s;
  logic [3:0]  col_s;
  rom_addr_t   addr_s;

  rom_addr_t   addr_r;
  logic        v1_r;
  logic        v2_r;
  pal_idx_t    rom_pix_s;

  assign edge_s = {vs_q1_r, vs_q0_r};

  // Vsync edge sampler plus per-frame shadow of position and facing.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs_q0_r       <= 1'b0;
      vs_q1_r       <= 1'b0;
      shadow_x_r    <= RST_X;
      shadow_y_r    <= RST_Y;
      facing_left_r <= 1'b0;
    end else begin
      vs_q0_r <= vga_vs;
      vs_q1_r <= vs_q0_r;
      if (edge_s == EDGE_FALL) begin
        shadow_x_r <= Doodle_X_in;
        shadow_y_r <= Doodle_Y_in;
        case (keycode)
          KEY_LEFT:  facing_left_r <= 1'b1;
          KEY_RIGHT: facing_left_r <= 1'b0;
          default:   facing_left_r <= facing_left_r;
        endcase
      end
    end
  end

  // Stage 0: screen pixel to game pixel, box test at 11 bits so shadow + size never wraps.
  always_comb begin
    gx_s     = {1'b0, pix.DrawX >> SCALE_SHIFT};
    gy_s     = {1'b0, pix.DrawY >> SCALE_SHIFT};
    sx_s     = {1'b0, shadow_x_r};
    sy_s     = {1'b0, shadow_y_r};
    in_box_s = (gx_s >= sx_s) && (gx_s < sx_s + {1'b0, SIZE_X}) &&
               (gy_s >= sy_s) && (gy_s < sy_s + {1'b0, SIZE_Y});
    // Offsets are below 16 inside the box, so the low nibble of the difference is exact.
    rel_x_s  = gx_s[3:0] - sx_s[3:0];
    rel_y_s  = gy_s[3:0] - sy_s[3:0];
    col_s    = rel_x_s;
    if (facing_left_r) begin
      col_s = SIZE_X[3:0] - 4'd1 - rel_x_s;
    end else begin
      col_s = rel_x_s;
    end
    addr_s = 7'd0;
    if (in_box_s) begin
      addr_s = {3'b000, rel_y_s} * SIZE_X[6:0] + {3'b000, col_s};
    end else begin
      addr_s = 7'd0;
    end
  end

  // Address register and valid pipe aligned with the ROM read.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_r <= 7'd0;
      v1_r   <= 1'b0;
      v2_r   <= 1'b0;
    end else begin
      addr_r <= addr_s;
      v1_r   <= in_box_s;
      v2_r   <= v1_r;
    end
  end

  doodle_sprite_rom u_rom (
    .Clk  (Clk),
    .addr (addr_r),
    .pix  (rom_pix_s)
  );

  assign pix.frame_clk_edge = edge_s;
  assign pix.doodle_on      = v2_r && (rom_pix_s != 4'd0);
  assign pix.doodle_idx     = (v2_r && (rom_pix_s != 4'd0)) ? rom_pix_s : 4'd0;

endmodule
